// File: rtl/mult_arbiter_if.sv
// Bundle of the signals that mult_arbiter exchanges with its two requesters and with the
// shared sequential multiplier.
//   slave  : arbiter view (takes requests and operands, drives the multiplier controls)
//   master : environment view (the requesters plus the multiplier)
// Requester side  : req0/req1, a0/b0/a1/b1 in; gnt0/gnt1, done0/done1, err0/err1, p0/p1, busy out
// Multiplier side : g, loada, loadb, mreset out; loadp, z in
interface mult_arbiter_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             err0;
  logic             err1;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] p1;
  logic             busy;
  logic             g;
  logic [WIDTH-1:0] loada;
  logic [WIDTH-1:0] loadb;
  logic             mreset;
  logic [WIDTH-1:0] loadp;
  logic             z;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, loadp, z,
    output gnt0, gnt1, done0, done1, err0, err1, p0, p1, busy, g, loada, loadb, mreset
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, loadp, z,
    input  gnt0, gnt1, done0, done1, err0, err1, p0, p1, busy, g, loada, loadb, mreset
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier between two requesters.
// A winner's operands are latched onto loada/loadb, the multiplier is started with g and
// polled on z, bounded by a TIMEOUT-cycle watchdog. The product is returned on p0/p1 with a
// done pulse, or an err pulse is raised on timeout; every operation ends with one mreset cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mult_arbiter_if.slave (requester handshake and multiplier control)
// All outputs are registers, decoded from the next state so they line up with the state:
//   ISSUE/WAIT -> g, CLEAR -> mreset plus done/err pulse, ISSUE..CLEAR -> gnt.
module mult_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst_n,
  mult_arbiter_if.slave bus
);

  localparam int unsigned     CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapture,
    StClear
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;      // preferred requester
  logic             sel_q, sel_d;      // requester currently being served
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] loada_q, loada_d;
  logic [WIDTH-1:0] loadb_q, loadb_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] p0_q, p0_d;
  logic [WIDTH-1:0] p1_q, p1_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             err0_q, err0_d;
  logic             err1_q, err1_d;
  logic             g_q, g_d;
  logic             mreset_q, mreset_d;
  logic             busy_q, busy_d;
  logic             win;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    loada_d  = loada_q;
    loadb_d  = loadb_q;
    cap_d    = cap_q;
    p0_d     = p0_q;
    p1_d     = p1_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    win      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          // Preferred requester wins if it is asking, otherwise the other one.
          win     = ptr_q ? bus.req1 : !bus.req0;
          sel_d   = win;
          loada_d = win ? bus.a1 : bus.a0;
          loadb_d = win ? bus.b1 : bus.b0;
          gnt0_d  = !win;
          gnt1_d  = win;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // z wins over the watchdog when both land in the same cycle.
        if (bus.z) begin
          cap_d   = bus.loadp;
          state_d = StCapture;
        end else if (cnt_q == CntMax) begin
          err0_d  = !sel_q;
          err1_d  = sel_q;
          state_d = StClear;
        end
      end
      StCapture: begin
        if (sel_q) begin
          p1_d    = cap_q;
          done1_d = 1'b1;
        end else begin
          p0_d    = cap_q;
          done0_d = 1'b1;
        end
        state_d = StClear;
      end
      StClear: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        ptr_d   = !sel_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    g_d      = (state_d == StIssue) || (state_d == StWait);
    mreset_d = (state_d == StClear);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b0;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      loada_q  <= '0;
      loadb_q  <= '0;
      cap_q    <= '0;
      p0_q     <= '0;
      p1_q     <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      g_q      <= 1'b0;
      mreset_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      loada_q  <= loada_d;
      loadb_q  <= loadb_d;
      cap_q    <= cap_d;
      p0_q     <= p0_d;
      p1_q     <= p1_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      g_q      <= g_d;
      mreset_q <= mreset_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.err0   = err0_q;
  assign bus.err1   = err1_q;
  assign bus.p0     = p0_q;
  assign bus.p1     = p1_q;
  assign bus.busy   = busy_q;
  assign bus.g      = g_q;
  assign bus.loada  = loada_q;
  assign bus.loadb  = loadb_q;
  assign bus.mreset = mreset_q;

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;

  logic clk;
  logic rst_n;

  mult_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mult_arbiter #(
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = done, 1 = err; grun = g-high cycles; gcyc = cycle index of the event from grant
  typedef struct {
    int id;
    int kind;
    int p;
    int grun;
    int gcyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   zdelay  = 0;  // WAIT cycle in which the multiplier raises z (0 = never)
  logic z_force = 1'b0;
  int   mcnt    = 0;
  int   gcyc    = 0;
  int   grun    = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Multiplier model: truncated product, z after zdelay WAIT cycles.
  always @(negedge clk) begin
    logic [2*WIDTH-1:0] prod;
    if (bus.g) mcnt++;
    else mcnt = 0;
    prod      = bus.loada * bus.loadb;
    bus.loadp = prod[WIDTH-1:0];
    bus.z     = z_force | (zdelay != 0 && bus.g && mcnt == zdelay + 1);
  end

  // Monitor: pops the scoreboard whenever a done/err pulse appears.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!(bus.gnt0 || bus.gnt1)) begin
      gcyc = 0;
      grun = 0;
    end else begin
      gcyc++;
      if (bus.g) grun++;
    end
    if (bus.done0 || bus.done1 || bus.err0 || bus.err1) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {28'd0, bus.done1, bus.done0, bus.err1, bus.err0}, 0);
      end else begin
        e = q.pop_front();
        chk("done_pulse", {30'd0, bus.done1, bus.done0}, e.kind == 0 ? (e.id ? 2 : 1) : 0);
        chk("err_pulse",  {30'd0, bus.err1, bus.err0},   e.kind == 1 ? (e.id ? 2 : 1) : 0);
        chk("product", e.id ? int'(bus.p1) : int'(bus.p0), e.p);
        chk("gnt_onehot", {30'd0, bus.gnt1, bus.gnt0}, e.id ? 2 : 1);
        chk("mreset_in_clear", int'(bus.mreset), 1);
        chk("g_cycles", grun, e.grun);
        chk("event_latency", gcyc, e.gcyc);
      end
    end
  end

  task automatic push(input int id, input int kind, input int p, input int n);
    exp_t e;
    e.id   = id;
    e.kind = kind;
    e.p    = p;
    e.grun = (kind == 0) ? n + 1 : TIMEOUT + 1;
    e.gcyc = (kind == 0) ? n + 3 : TIMEOUT + 2;
    q.push_back(e);
  endtask

  task automatic wait_ev(input int id, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (id == 0 && (bus.done0 || bus.err0)) return;
      if (id == 1 && (bus.done1 || bus.err1)) return;
    end
    chk("wait_event_timeout", 0, 1);
  endtask

  task automatic wait_gnt(input int id, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (id == 0 && bus.gnt0) return;
      if (id == 1 && bus.gnt1) return;
    end
    chk("wait_grant_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ctrl"}, {23'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1,
                          bus.busy, bus.g, bus.mreset}, 0);
    chk({name, "_data"}, int'({bus.loada, bus.loadb, bus.p0, bus.p1}), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0 = '0;
    bus.b0 = '0;
    bus.a1 = '0;
    bus.b1 = '0;
    bus.z     = 1'b0;
    bus.loadp = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // 25 x 5, z after 10 WAIT cycles
    zdelay = 10;
    bus.a0 = 8'd25;
    bus.b0 = 8'd5;
    bus.req0 = 1'b1;
    push(0, 0, 125, 10);
    wait_ev(0, 40);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_after_done", int'(bus.busy), 0);
    chk("p0_held", int'(bus.p0), 125);
    chk("mreset_single", int'(bus.mreset), 0);

    // Simultaneous requests after reset: requester 0 first
    do_reset();
    @(negedge clk);
    zdelay = 3;
    bus.a0 = 8'd3;
    bus.b0 = 8'd4;
    bus.a1 = 8'd6;
    bus.b1 = 8'd7;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    push(0, 0, 12, 3);
    push(1, 0, 42, 3);
    wait_ev(0, 40);
    bus.req0 = 1'b0;
    wait_ev(1, 40);
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Both held for four grants: order 0,1,0,1
    zdelay = 2;
    bus.a0 = 8'd9;
    bus.b0 = 8'd9;
    bus.a1 = 8'd10;
    bus.b1 = 8'd13;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    push(0, 0, 81, 2);
    push(1, 0, 130, 2);
    push(0, 0, 81, 2);
    push(1, 0, 130, 2);
    wait_ev(0, 40);
    wait_ev(1, 40);
    wait_ev(0, 40);
    wait_ev(1, 40);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout: z never arrives, p0 keeps 81
    zdelay = 0;
    bus.a0 = 8'd7;
    bus.b0 = 8'd7;
    bus.req0 = 1'b1;
    push(0, 1, 81, 0);
    wait_ev(0, 120);
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);

    // z on the last allowed WAIT cycle counts as success; product truncated (272 -> 16)
    zdelay = TIMEOUT;
    bus.a1 = 8'd16;
    bus.b1 = 8'd17;
    bus.req1 = 1'b1;
    push(1, 0, 16, TIMEOUT);
    wait_ev(1, 120);
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Request dropped mid-WAIT with new operand: result uses latched 11 x 12
    zdelay = 6;
    bus.a0 = 8'd11;
    bus.b0 = 8'd12;
    bus.req0 = 1'b1;
    push(0, 0, 132, 6);
    wait_gnt(0, 10);
    repeat (3) @(negedge clk);
    bus.req0 = 1'b0;
    bus.a0 = 8'd99;
    @(negedge clk);
    chk("loada_stable", int'(bus.loada), 11);
    wait_ev(0, 40);
    repeat (2) @(negedge clk);

    // z while idle is ignored
    z_force = 1'b1;
    repeat (4) @(negedge clk);
    chk("z_idle_no_busy", int'(bus.busy), 0);
    z_force = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in WAIT: everything clears at once, operation discarded
    zdelay = 20;
    bus.a0 = 8'd5;
    bus.b0 = 8'd5;
    bus.req0 = 1'b1;
    wait_gnt(0, 10);
    repeat (4) @(negedge clk);
    chk("in_wait_before_reset", int'(bus.g), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    bus.req0 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    zdelay = 2;
    bus.a1 = 8'd2;
    bus.b1 = 8'd2;
    bus.req1 = 1'b1;
    push(1, 0, 4, 2);
    wait_ev(1, 40);
    bus.req1 = 1'b0;
    repeat (5) @(negedge clk);

    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
